// File: rtl/seg7_scan_reader.sv
// Recovers hex digits from a multiplexed, active-low 7-segment display scan.
// Optional decimal-point capture is enabled by defining SEG7_READER_DP_EN.
module seg7_scan_reader #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg_n,
    input  logic [3:0]  dig_en_n,
`ifdef SEG7_READER_DP_EN
    input  logic        dp_n,
    output logic [3:0]  dp,
`endif
    output logic [15:0] digits,
    output logic [3:0]  valid,
    output logic        pat_err,
    output logic        strobe_err,
    output logic        frame_done
);

`ifdef SEG7_READER_DP_EN
    localparam int SW = 12;
`else
    localparam int SW = 11;
`endif

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    localparam logic [7:0] LP_STABLE = 8'(STABLE_CYCLES);

    function automatic logic [2:0] f_low_count(input logic [3:0] v);
        logic [2:0] n;
        n = '0;
        for (int k = 0; k < 4; k++) begin
            n = n + {2'b00, ~v[k]};
        end
        return n;
    endfunction

    function automatic logic [1:0] f_idx(input logic [3:0] v);
        case (v)
            4'b1110: return 2'd0;
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Returns {legal, value}; lit is the gfedcba pattern with 1 = segment on.
    function automatic logic [4:0] f_decode(input logic [6:0] lit);
        case (lit)
            7'h3F:   return {1'b1, 4'h0};
            7'h06:   return {1'b1, 4'h1};
            7'h5B:   return {1'b1, 4'h2};
            7'h4F:   return {1'b1, 4'h3};
            7'h66:   return {1'b1, 4'h4};
            7'h6D:   return {1'b1, 4'h5};
            7'h7D:   return {1'b1, 4'h6};
            7'h07:   return {1'b1, 4'h7};
            7'h7F:   return {1'b1, 4'h8};
            7'h6F:   return {1'b1, 4'h9};
            7'h77:   return {1'b1, 4'hA};
            7'h7C:   return {1'b1, 4'hB};
            7'h39:   return {1'b1, 4'hC};
            7'h5E:   return {1'b1, 4'hD};
            7'h79:   return {1'b1, 4'hE};
            7'h71:   return {1'b1, 4'hF};
            default: return 5'h00;
        endcase
    endfunction

    logic [SW-1:0] w_in;
    logic [SW-1:0] r_sync_p0;
    logic [SW-1:0] r_sync_p1;
    logic [SW-1:0] r_ref;
    logic [SW-1:0] w_ref_nx;
    logic [1:0]    r_state;
    logic [1:0]    w_state_nx;
    logic [7:0]    r_cnt;
    logic [7:0]    w_cnt_nx;
    logic [7:0]    w_cnt_inc;
    logic          w_capture;
    logic [3:0]    w_dig;
    logic [2:0]    w_low;
    logic          w_onehot;
    logic          w_multi;
    logic          w_changed;
    logic          r_multi_q;
    logic [1:0]    w_idx;
    logic [4:0]    w_dec;
    logic [3:0]    w_valid_after;
    logic [15:0]   r_digits;
    logic [3:0]    r_valid;
    logic          r_pat_err;
    logic          r_strobe_err;
    logic          r_frame_done;

`ifdef SEG7_READER_DP_EN
    logic [3:0]    r_dp;
    assign w_in = {dp_n, dig_en_n, seg_n};
    assign dp   = r_dp;
`else
    assign w_in = {dig_en_n, seg_n};
`endif

    // Stage p0/p1: two-flop synchronizer, idles at "nothing lit, no strobe".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_p0 <= '1;
            r_sync_p1 <= '1;
        end else begin
            r_sync_p0 <= w_in;
            r_sync_p1 <= r_sync_p0;
        end
    end

    assign w_dig     = r_sync_p1[10:7];
    assign w_low     = f_low_count(w_dig);
    assign w_onehot  = (w_low == 3'd1);
    assign w_multi   = (w_low > 3'd1);
    assign w_changed = (r_sync_p1 != r_ref);
    assign w_cnt_inc = r_cnt + 8'd1;

    // The reference sample counts as the first stable cycle.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_ref_nx   = r_ref;
        w_capture  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_onehot) begin
                    w_ref_nx   = r_sync_p1;
                    w_cnt_nx   = 8'd1;
                    w_state_nx = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (w_changed) begin
                    w_ref_nx   = r_sync_p1;
                    w_cnt_nx   = 8'd1;
                    w_state_nx = w_onehot ? ST_SETTLE : ST_IDLE;
                end else if (w_cnt_inc >= LP_STABLE) begin
                    w_cnt_nx   = w_cnt_inc;
                    w_capture  = 1'b1;
                    w_state_nx = ST_HOLD;
                end else begin
                    w_cnt_nx   = w_cnt_inc;
                end
            end
            ST_HOLD: begin
                if (w_changed) begin
                    w_ref_nx = r_sync_p1;
                    if (w_onehot) begin
                        w_cnt_nx   = 8'd1;
                        w_state_nx = ST_SETTLE;
                    end else begin
                        w_cnt_nx   = 8'd0;
                        w_state_nx = ST_IDLE;
                    end
                end
            end
            default: begin
                w_cnt_nx   = 8'd0;
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // Stage p2: scan FSM and reference sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            r_ref   <= '1;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_ref   <= w_ref_nx;
        end
    end

    assign w_idx         = f_idx(r_ref[10:7]);
    assign w_dec         = f_decode(~r_ref[6:0]);
    assign w_valid_after = r_valid | (4'b0001 << w_idx);

    // Stage p3: captured digits and one-cycle status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_digits     <= 16'h0000;
            r_valid      <= 4'b0000;
            r_pat_err    <= 1'b0;
            r_strobe_err <= 1'b0;
            r_frame_done <= 1'b0;
            r_multi_q    <= 1'b0;
`ifdef SEG7_READER_DP_EN
            r_dp         <= 4'b0000;
`endif
        end else begin
            r_pat_err    <= 1'b0;
            r_frame_done <= 1'b0;
            r_multi_q    <= w_multi;
            r_strobe_err <= w_multi & ~r_multi_q;
            if (w_capture) begin
`ifdef SEG7_READER_DP_EN
                r_dp[w_idx] <= ~r_ref[11];
`endif
                if (w_dec[4]) begin
                    r_digits[{w_idx, 2'b00} +: 4] <= w_dec[3:0];
                    r_valid[w_idx]                <= 1'b1;
                    r_frame_done <= (w_idx == 2'd3) && (&w_valid_after);
                end else begin
                    r_valid[w_idx] <= 1'b0;
                    r_pat_err      <= 1'b1;
                end
            end
        end
    end

    assign digits     = r_digits;
    assign valid      = r_valid;
    assign pat_err    = r_pat_err;
    assign strobe_err = r_strobe_err;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Randomized self-checking bench for seg7_scan_reader against a transaction-level model.
// Define SEG7_READER_DP_EN to also exercise the decimal-point capture.
module tb_seg7_scan_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg_n;
    logic [3:0]  dig_en_n;
    logic [15:0] digits;
    logic [3:0]  valid;
    logic        pat_err;
    logic        strobe_err;
    logic        frame_done;
`ifdef SEG7_READER_DP_EN
    logic        dp_n_r;
    logic [3:0]  dp_o;
`endif

    seg7_scan_reader #(.STABLE_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_n      (seg_n),
        .dig_en_n   (dig_en_n),
`ifdef SEG7_READER_DP_EN
        .dp_n       (dp_n_r),
        .dp         (dp_o),
`endif
        .digits     (digits),
        .valid      (valid),
        .pat_err    (pat_err),
        .strobe_err (strobe_err),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse totals, written only by this monitor.
    int t_pe = 0, t_fd = 0, t_se = 0, t_both = 0;
    always @(negedge clk) begin
        if (pat_err)               t_pe++;
        if (frame_done)            t_fd++;
        if (strobe_err)            t_se++;
        if (pat_err && frame_done) t_both++;
    end

    // Reference model: lit-segment table indexed by hex value.
    logic [6:0] lit_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [3:0] m_dig [4];
    logic [3:0] m_valid;
    logic [6:0] m_prev_s;
    logic [3:0] m_prev_d;

    task automatic model_reset();
        for (int k = 0; k < 4; k++) m_dig[k] = 4'h0;
        m_valid  = 4'b0000;
        m_prev_s = 7'h7F;
        m_prev_d = 4'hF;
    endtask

    function automatic logic [15:0] m_digits();
        return {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
    endfunction

    // Hold one input pattern for ncyc cycles, predicting the outcome first.
    task automatic apply_hold(input logic [6:0] s, input logic [3:0] d, input int ncyc, input bit do_chk);
        int nl, idx, v, e_pe, e_fd, e_se, b_pe, b_fd, b_se;
        bit cap;
        nl = $countones(~d);
        e_pe = 0; e_fd = 0; e_se = 0;
        e_se = (nl > 1 && $countones(~m_prev_d) <= 1) ? 1 : 0;
        cap = (nl == 1) && !(s == m_prev_s && d == m_prev_d);
        if (cap) begin
            idx = 0;
            for (int k = 0; k < 4; k++) if (!d[k]) idx = k;
            v = -1;
            for (int k = 0; k < 16; k++) if (lit_tab[k] == ~s) v = k;
            if (v >= 0) begin
                m_dig[idx]   = v[3:0];
                m_valid[idx] = 1'b1;
                if (idx == 3 && m_valid == 4'hF) e_fd = 1;
            end else begin
                m_valid[idx] = 1'b0;
                e_pe = 1;
            end
        end
        m_prev_s = s;
        m_prev_d = d;
        @(posedge clk);
        #1;
        b_pe = t_pe; b_fd = t_fd; b_se = t_se;
        seg_n    = s;
        dig_en_n = d;
        repeat (ncyc - 1) @(posedge clk);
        @(negedge clk);
        #1;
        if (do_chk) begin
            chk("digits", digits, m_digits());
            chk("valid", valid, m_valid);
            chk("pat_err_pulses", t_pe - b_pe, e_pe);
            chk("frame_done_pulses", t_fd - b_fd, e_fd);
            chk("strobe_err_pulses", t_se - b_se, e_se);
        end
    endtask

    task automatic gap();
        apply_hold(7'h7F, 4'hF, 2, 1'b0);
    endtask

    initial begin
        logic [6:0] s;
        logic [3:0] d;
        int r, b_pe;

        rst = 1'b1;
        seg_n = 7'h7F;
        dig_en_n = 4'hF;
`ifdef SEG7_READER_DP_EN
        dp_n_r = 1'b1;
`endif
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_digits", digits, 16'h0000);
        chk("rst_valid", valid, 4'b0000);
        chk("rst_pulses", {pat_err, strobe_err, frame_done}, 3'b000);

        // Single digit capture.
        apply_hold(~7'h5B, 4'b1110, 8, 1'b1);
        chk("single_digit0", digits[3:0], 4'h2);
        gap();

        // Full frame scan.
        apply_hold(~7'h06, 4'b1110, 8, 1'b1);
        apply_hold(~7'h5B, 4'b1101, 8, 1'b1);
        apply_hold(~7'h4F, 4'b1011, 8, 1'b1);
        apply_hold(~7'h71, 4'b0111, 8, 1'b1);
        chk("frame_digits", digits, 16'hF321);
        chk("frame_valid", valid, 4'hF);
        gap();

`ifdef SEG7_READER_DP_EN
        dp_n_r = 1'b0;
        apply_hold(~7'h7F, 4'b1011, 8, 1'b1);
        chk("dp_digit2", dp_o, 4'b0100);
        dp_n_r = 1'b1;
        gap();
        apply_hold(~7'h4F, 4'b1011, 8, 1'b1);
        gap();
`endif

        // Illegal (blank) pattern on digit 1.
        apply_hold(~7'h00, 4'b1101, 8, 1'b1);
        chk("illegal_nibble", digits[7:4], 4'h2);
        chk("illegal_valid", valid, 4'b1101);
        gap();

        // Two strobes low.
        apply_hold(~7'h06, 4'b1100, 8, 1'b1);
        gap();

        // Glitch every third cycle: never four stable samples in a row.
        b_pe = t_pe;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            seg_n    = (i % 3 == 2) ? ~7'h7F : ~7'h6F;
            dig_en_n = 4'b1101;
        end
        m_prev_s = ~7'h7F;
        m_prev_d = 4'b1101;
        @(negedge clk);
        chk("glitch_digits", digits, m_digits());
        chk("glitch_valid", valid, m_valid);
        chk("glitch_pat_err", t_pe - b_pe, 0);
        gap();

        // Reset while a capture is pending.
        @(posedge clk);
        #1;
        seg_n = ~7'h07;
        dig_en_n = 4'b1110;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        chk("midrst_digits", digits, 16'h0000);
        chk("midrst_valid", valid, 4'b0000);
        chk("midrst_pulses", {pat_err, strobe_err, frame_done}, 3'b000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("midrst_no_early_capture", valid, 4'b0000);
        apply_hold(~7'h07, 4'b1110, 8, 1'b1);

        // Randomized scan traffic.
        for (int t = 0; t < 150; t++) begin
            r = $urandom_range(0, 99);
            if (r < 8) begin
                s = m_prev_s;
                d = m_prev_d;
            end else if (r < 18) begin
                d = 4'(($urandom_range(0, 15)));
                while ($countones(~d) < 2) d = 4'(($urandom_range(0, 15)));
                s = 7'($urandom_range(0, 127));
            end else if (r < 25) begin
                s = 7'h7F;
                d = 4'hF;
            end else begin
                d = ~(4'b0001 << $urandom_range(0, 3));
                if ($urandom_range(0, 4) != 0) begin
                    s = ~lit_tab[$urandom_range(0, 15)];
                end else begin
                    s = 7'($urandom_range(0, 127));
                end
            end
            apply_hold(s, d, 8, 1'b1);
            if ($urandom_range(0, 2) == 0) gap();
        end

        chk("pe_fd_exclusive", t_both, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
